addr8s_dmr_sched: RTL and testbench

- Round-robin scheduler that shares one combinational 8-bit signed adder (9-bit sum) among NREQ requesters.
- Each accepted operation is executed twice on the shared adder: pass 1 with operands (A,B), pass 2 with operands swapped (B,A), so different gate paths are exercised. The two sums are compared.
- On mismatch the operation is retried up to MAX_RETRY times. If it still mismatches, the result is returned flagged as an error.
- Sits between requesting datapath units and the fault-resilient adder core; it adds temporal redundancy on top of the core's structural resilience.

---
 rtl/addr8s_pkg.sv | 19 +
 rtl/add8s_core.sv | 13 +
 rtl/addr8s_dmr_sched.sv | 183 ++++++++++++++++++
 tb/tb_addr8s_dmr_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr8s_pkg.sv
// rtl/addr8s_pkg.sv - shared types and helpers for the dual-pass adder scheduler
package addr8s_pkg;

    localparam int OP_W  = 8;
    localparam int SUM_W = 9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        CHK  = 3'd3,
        RESP = 3'd4
    } state_e;

    function automatic logic [SUM_W-1:0] sext9(input logic [OP_W-1:0] v);
        return {v[OP_W-1], v};
    endfunction

endpackage

// File: rtl/add8s_core.sv
// rtl/add8s_core.sv - combinational 8-bit signed adder, 9-bit result
module add8s_core
    import addr8s_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [SUM_W-1:0] sum
);

    // Sign extension to 9 bits makes the sum exact for any operand pair.
    assign sum = sext9(a) + sext9(b);

endmodule

// File: rtl/addr8s_dmr_sched.sv
// rtl/addr8s_dmr_sched.sv - round-robin scheduler running each add twice on one shared adder
module addr8s_dmr_sched
    import addr8s_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*OP_W-1:0]     req_a,
    input  logic [NREQ*OP_W-1:0]     req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [SUM_W-1:0]         rsp_sum,
    output logic                     rsp_err,
    input  logic                     cfg_dual_en,
    input  logic [SUM_W-1:0]         flt_mask,
    output logic [CNT_W-1:0]         mismatch_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [2:0]         retry_q, retry_d;
    logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
    logic [SUM_W-1:0]   s1_q, s1_d, s2_q, s2_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   mis_q, mis_d, errc_q, errc_d;

    logic [OP_W-1:0]    add_a, add_b;
    logic [SUM_W-1:0]   add_sum;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gidx;
    logic               found;
    int                 rr_idx;

    // Pass 2 swaps the operands so the two passes exercise different gate paths.
    assign add_a = (state_q == P2) ? b_q : a_q;
    assign add_b = (state_q == P2) ? a_q : b_q;

    add8s_core u_core (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    always_comb begin
        gidx   = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (!found && req_valid[rr_idx]) begin
                found = 1'b1;
                gidx  = IDW'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        retry_d = retry_q;
        a_d     = a_q;
        b_d     = b_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        sum_d   = sum_q;
        err_d   = err_q;
        mis_d   = mis_q;
        errc_d  = errc_q;
        grant   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant[gidx] = 1'b1;
                    a_d     = req_a[int'(gidx)*OP_W +: OP_W];
                    b_d     = req_b[int'(gidx)*OP_W +: OP_W];
                    id_d    = gidx;
                    state_d = P1;
                end
            end
            P1: begin
                s1_d = add_sum ^ flt_mask;
                if (cfg_dual_en) begin
                    state_d = P2;
                end else begin
                    sum_d   = add_sum ^ flt_mask;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            P2: begin
                s2_d    = add_sum;
                state_d = CHK;
            end
            CHK: begin
                if (s1_q == s2_q) begin
                    sum_d   = s1_q;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    if (mis_q != '1) begin
                        mis_d = mis_q + 1'b1;
                    end
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 3'd1;
                        state_d = P1;
                    end else begin
                        if (errc_q != '1) begin
                            errc_d = errc_q + 1'b1;
                        end
                        sum_d   = s1_q;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                    retry_d = 3'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            retry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            retry_q <= retry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            errc_q  <= errc_d;
        end
    end

    // The grant is combinational from IDLE, so it is masked while reset is held.
    assign req_ready    = grant & {NREQ{rst_n}};
    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = id_q;
    assign rsp_sum      = sum_q;
    assign rsp_err      = err_q;
    assign mismatch_cnt = mis_q;
    assign err_cnt      = errc_q;

endmodule

// File: tb/tb_addr8s_dmr_sched.sv
// tb/tb_addr8s_dmr_sched.sv - directed self-checking bench for the dual-pass adder scheduler
module tb_addr8s_dmr_sched;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_a = '0;
    logic [NREQ*8-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [8:0]        rsp_sum;
    logic              rsp_err;
    logic              cfg_dual_en = 1'b1;
    logic [8:0]        flt_mask = '0;
    logic [7:0]        mismatch_cnt;
    logic [7:0]        err_cnt;

    int total = 0;
    int bad = 0;

    addr8s_dmr_sched #(.NREQ(4), .MAX_RETRY(2), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_err      (rsp_err),
        .cfg_dual_en  (cfg_dual_en),
        .flt_mask     (flt_mask),
        .mismatch_cnt (mismatch_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_valid[i] = 1'b1;
    endtask

    // Advances from the current cycle until rsp_valid, bounded; cyc counts cycles since grant.
    task automatic wait_rsp(input int start, output int cyc);
        cyc = start;
        while (!rsp_valid && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        set_req(0, 8'h11, 8'h22);
        #2;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, mismatch_cnt, err_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b id=%0d sum=%h err=%b mis=%0d errc=%0d, required all 0",
                     req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, mismatch_cnt, err_cnt);
        end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        do_reset();
        set_req(0, 8'h7F, 8'h7F);
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL basic_grant: got %b, required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        wait_rsp(1, cyc);
        total++;
        if (cyc !== 4) begin
            bad++;
            $display("FAIL basic_latency: got %0d, required 4", cyc);
        end
        total++;
        if ({rsp_id, rsp_sum, rsp_err, mismatch_cnt} !== {2'd0, 9'h0FE, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL basic_payload: id=%0d sum=%h err=%b mis=%0d, required 0 0fe 0 0",
                     rsp_id, rsp_sum, rsp_err, mismatch_cnt);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_handshake: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        int cyc;
        int cnt;
        logic [3:0] exp_g;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h80, 8'h80);
        for (int k = 0; k < 5; k++) begin
            #1;
            cnt = 0;
            while (req_ready == '0 && cnt < 20) begin
                tick();
                cnt++;
            end
            exp_g = 4'b0001 << exp_rr[k];
            total++;
            if (req_ready !== exp_g) begin
                bad++;
                $display("FAIL rr_grant%0d: got %b, required %b", k, req_ready, exp_g);
            end
            tick();
            wait_rsp(1, cyc);
            total++;
            if ({cyc[3:0], rsp_id, rsp_sum, rsp_err} !== {4'd4, 2'(exp_rr[k]), 9'h100, 1'b0}) begin
                bad++;
                $display("FAIL rr_rsp%0d: cyc=%0d id=%0d sum=%h err=%b, required 4 %0d 100 0",
                         k, cyc, rsp_id, rsp_sum, rsp_err, exp_rr[k]);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_transient();
        int cyc;
        do_reset();
        set_req(2, 8'h05, 8'hFD);
        flt_mask = 9'h001;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL trans_grant: got %b, required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        flt_mask = 9'h000;
        wait_rsp(2, cyc);
        total++;
        if (cyc !== 7) begin
            bad++;
            $display("FAIL trans_latency: got %0d, required 7", cyc);
        end
        total++;
        if ({rsp_id, rsp_sum, rsp_err, mismatch_cnt, err_cnt} !== {2'd2, 9'h002, 1'b0, 8'd1, 8'd0}) begin
            bad++;
            $display("FAIL trans_payload: id=%0d sum=%h err=%b mis=%0d errc=%0d, required 2 002 0 1 0",
                     rsp_id, rsp_sum, rsp_err, mismatch_cnt, err_cnt);
        end
        tick();
    endtask

    task automatic test_persistent();
        int cyc;
        do_reset();
        set_req(1, 8'h10, 8'h20);
        flt_mask = 9'h100;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL pers_grant: got %b, required 0010", req_ready);
        end
        tick();
        req_valid = '0;
        wait_rsp(1, cyc);
        total++;
        if (cyc !== 10) begin
            bad++;
            $display("FAIL pers_latency: got %0d, required 10", cyc);
        end
        total++;
        if ({rsp_id, rsp_sum, rsp_err, mismatch_cnt, err_cnt} !== {2'd1, 9'h130, 1'b1, 8'd3, 8'd1}) begin
            bad++;
            $display("FAIL pers_payload: id=%0d sum=%h err=%b mis=%0d errc=%0d, required 1 130 1 3 1",
                     rsp_id, rsp_sum, rsp_err, mismatch_cnt, err_cnt);
        end
        flt_mask = 9'h000;
        tick();
    endtask

    task automatic test_backpressure_single();
        int cyc;
        do_reset();
        cfg_dual_en = 1'b0;
        rsp_ready = 1'b0;
        set_req(3, 8'h81, 8'hFE);
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL bp_grant: got %b, required 1000", req_ready);
        end
        tick();
        req_valid = '0;
        set_req(0, 8'h40, 8'h40);
        wait_rsp(1, cyc);
        total++;
        if (cyc !== 2) begin
            bad++;
            $display("FAIL bp_latency: got %0d, required 2", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_err, req_ready} !== {1'b1, 2'd3, 9'h17F, 1'b0, 4'b0000}) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b id=%0d sum=%h err=%b ready=%b, required 1 3 17f 0 0000",
                         i, rsp_valid, rsp_id, rsp_sum, rsp_err, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL bp_next_grant: got %b, required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        wait_rsp(1, cyc);
        total++;
        if ({cyc[3:0], rsp_id, rsp_sum, mismatch_cnt} !== {4'd2, 2'd0, 9'h080, 8'd0}) begin
            bad++;
            $display("FAIL bp_second: cyc=%0d id=%0d sum=%h mis=%0d, required 2 0 080 0",
                     cyc, rsp_id, rsp_sum, mismatch_cnt);
        end
        tick();
        cfg_dual_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        set_req(1, 8'h01, 8'h02);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, mismatch_cnt, err_cnt} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: ready=%b valid=%b id=%0d sum=%h err=%b mis=%0d errc=%0d, required all 0",
                     req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, mismatch_cnt, err_cnt);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({req_ready, rsp_valid} !== {4'b0010, 1'b0}) begin
            bad++;
            $display("FAIL midrst_regrant: ready=%b valid=%b, required 0010 0", req_ready, rsp_valid);
        end
        tick();
        req_valid = '0;
        wait_rsp(1, cyc);
        total++;
        if ({cyc[3:0], rsp_id, rsp_sum, rsp_err} !== {4'd4, 2'd1, 9'h003, 1'b0}) begin
            bad++;
            $display("FAIL midrst_rsp: cyc=%0d id=%0d sum=%h err=%b, required 4 1 003 0",
                     cyc, rsp_id, rsp_sum, rsp_err);
        end
        tick();
    endtask

    task automatic test_saturation();
        int cyc;
        do_reset();
        flt_mask = 9'h100;
        for (int n = 0; n < 90; n++) begin
            set_req(0, 8'hFF, 8'h01);
            #1;
            tick();
            req_valid = '0;
            wait_rsp(1, cyc);
            tick();
        end
        flt_mask = 9'h000;
        total++;
        if ({mismatch_cnt, err_cnt} !== {8'd255, 8'd90}) begin
            bad++;
            $display("FAIL sat_counters: mis=%0d errc=%0d, required 255 90", mismatch_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_transient();
        test_persistent();
        test_backpressure_single();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
